truth_table_scanner: RTL and testbench

- Sequential stimulus/capture stage placed directly upstream of the lab's combinational function blocks (F1, F2, comp_F3, F4 and similar).
- On a start request it drives every input combination onto the function block in ascending order and waits a programmable settle time per vector.
- It samples the function output for each vector, building the complete truth table and a count of true minterms.
- It compares the captured table against an expected table and reports mismatch with a done pulse.

---
 rtl/truth_table_scanner.sv | 101 ++++++++++
 tb/tb_truth_table_scanner.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Truth table scanner: walks every input vector of a combinational block,
// samples its output after a settle time and compares against an expected table.
module truth_table_scanner #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_table,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      dut_in,
  output logic [2**N_IN-1:0]   table_q,
  output logic [N_IN:0]        ones_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 mismatch
);

  localparam int DEPTH = 2**N_IN;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    FINISH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [DEPTH-1:0] exp_q;
  logic [DEPTH-1:0] tbl_nxt;
  logic             accept;
  logic             settled;
  logic             last;

  // FINISH also accepts start so held-high start gives back-to-back scans
  assign accept  = start && (state == IDLE || state == FINISH);
  assign settled = cnt == 4'(SETTLE - 1);
  assign last    = &dut_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   if (settled) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = last ? FINISH : DRIVE;
      FINISH:  state_nxt = start ? DRIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = state != IDLE;
    done = state == FINISH;
  end

  always_comb begin
    tbl_nxt          = table_q;
    tbl_nxt[dut_in]  = dut_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in   <= '0;
      table_q  <= '0;
      ones_cnt <= '0;
      mismatch <= 1'b0;
      cnt      <= '0;
      exp_q    <= '0;
    end else if (accept) begin
      dut_in   <= '0;
      table_q  <= '0;
      ones_cnt <= '0;
      mismatch <= 1'b0;
      cnt      <= '0;
      exp_q    <= exp_table;
    end else begin
      unique case (state)
        DRIVE: begin
          cnt <= settled ? 4'd0 : cnt + 4'd1;
        end
        SAMPLE: begin
          table_q  <= tbl_nxt;
          ones_cnt <= ones_cnt + (N_IN+1)'(dut_out);
          // mismatch uses the table including this final sample
          if (last) mismatch <= tbl_nxt != exp_q;
          else      dut_in   <= dut_in + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: three scanner instances (N_IN 4/2/3) driving modelled
// F4, F1/F2 and comp_F3 function blocks.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance a: N_IN=4 SETTLE=2, F4 = c ^ d
  logic        start_a = 1'b0;
  logic [15:0] exp_a = '0;
  logic        out_a;
  logic [3:0]  din_a;
  logic [15:0] tbl_a;
  logic [4:0]  ones_a;
  logic        busy_a, done_a, mis_a;
  assign out_a = din_a[1] ^ din_a[0];

  // instance b: N_IN=2 SETTLE=2, F1 = a, F2 = a | (a & b), or tied 1
  logic        start_b = 1'b0;
  logic [3:0]  exp_b = '0;
  logic        f2_sel = 1'b0;
  logic        tie1 = 1'b0;
  logic        out_b;
  logic [1:0]  din_b;
  logic [3:0]  tbl_b;
  logic [2:0]  ones_b;
  logic        busy_b, done_b, mis_b;
  assign out_b = tie1 ? 1'b1 :
                 f2_sel ? (din_b[1] | (din_b[1] & din_b[0])) : din_b[1];

  // instance c: N_IN=3 SETTLE=1, comp_F3 = a'c' + ab'
  logic        start_c = 1'b0;
  logic [7:0]  exp_c = '0;
  logic        out_c;
  logic [2:0]  din_c;
  logic [7:0]  tbl_c;
  logic [3:0]  ones_c;
  logic        busy_c, done_c, mis_c;
  assign out_c = (~din_c[2] & ~din_c[0]) | (din_c[2] & ~din_c[1]);

  truth_table_scanner #(.N_IN(4), .SETTLE(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .exp_table(exp_a),
    .dut_out(out_a), .dut_in(din_a), .table_q(tbl_a),
    .ones_cnt(ones_a), .busy(busy_a), .done(done_a), .mismatch(mis_a)
  );

  truth_table_scanner #(.N_IN(2), .SETTLE(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .exp_table(exp_b),
    .dut_out(out_b), .dut_in(din_b), .table_q(tbl_b),
    .ones_cnt(ones_b), .busy(busy_b), .done(done_b), .mismatch(mis_b)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .exp_table(exp_c),
    .dut_out(out_c), .dut_in(din_c), .table_q(tbl_c),
    .ones_cnt(ones_c), .busy(busy_c), .done(done_c), .mismatch(mis_c)
  );

  // Pulse start on one instance; returns #1 after the accepting edge.
  task automatic kick(input int which);
    @(negedge clk);
    case (which)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Cycle number (accepting edge = cycle 0 boundary) in which done is high; -1 on timeout.
  task automatic wait_done(input int which, output int cyc);
    logic d;
    cyc = -1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      case (which)
        0: d = done_a;
        1: d = done_b;
        default: d = done_c;
      endcase
      if (d) begin
        cyc = k + 1;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({din_a, tbl_a, ones_a, busy_a, done_a, mis_a} !== '0) begin
      errors++;
      $display("FAIL reset_a got %h want 0",
               {din_a, tbl_a, ones_a, busy_a, done_a, mis_a});
    end
    checks++;
    if ({din_b, tbl_b, ones_b, busy_b, done_b, mis_b,
         din_c, tbl_c, ones_c, busy_c, done_c, mis_c} !== '0) begin
      errors++;
      $display("FAIL reset_bc got nonzero outputs");
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_f4;
    int cyc;
    exp_a = 16'h6666;
    kick(0);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL f4_busy_start got %b want 1", busy_a);
    end
    wait_done(0, cyc);
    checks++;
    if (cyc !== 49) begin
      errors++;
      $display("FAIL f4_latency got %0d want 49", cyc);
    end
    checks++;
    if (tbl_a !== 16'h6666 || ones_a !== 5'd8 || mis_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL f4_result got tbl=%h ones=%0d mis=%b busy=%b want 6666 8 0 1",
               tbl_a, ones_a, mis_a, busy_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || din_a !== 4'hF || tbl_a !== 16'h6666) begin
      errors++;
      $display("FAIL f4_idle_hold got done=%b busy=%b din=%h tbl=%h want 0 0 f 6666",
               done_a, busy_a, din_a, tbl_a);
    end
  endtask

  task automatic test_f1_f2;
    int cyc;
    for (int s = 0; s < 2; s++) begin
      f2_sel = (s == 1);
      exp_b = 4'hC;
      kick(1);
      wait_done(1, cyc);
      checks++;
      if (cyc !== 13) begin
        errors++;
        $display("FAIL f%0d_latency got %0d want 13", s + 1, cyc);
      end
      checks++;
      if (tbl_b !== 4'hC || ones_b !== 3'd2 || mis_b !== 1'b0) begin
        errors++;
        $display("FAIL f%0d_result got tbl=%h ones=%0d mis=%b want c 2 0",
                 s + 1, tbl_b, ones_b, mis_b);
      end
    end
    f2_sel = 1'b0;
  endtask

  task automatic test_f3;
    int cyc;
    logic [7:0] exps [2];
    exps[0] = 8'h35;
    exps[1] = 8'h34;
    for (int s = 0; s < 2; s++) begin
      exp_c = exps[s];
      kick(2);
      wait_done(2, cyc);
      checks++;
      if (cyc !== 17) begin
        errors++;
        $display("FAIL f3_latency_%0d got %0d want 17", s, cyc);
      end
      checks++;
      if (tbl_c !== 8'h35 || ones_c !== 4'd4 || mis_c !== (s == 1)) begin
        errors++;
        $display("FAIL f3_result_%0d got tbl=%h ones=%0d mis=%b want 35 4 %0d",
                 s, tbl_c, ones_c, mis_c, s);
      end
    end
  endtask

  task automatic test_restart_ignored;
    int first = -1;
    int pulses = 0;
    exp_a = 16'h6666;
    kick(0);
    for (int k = 1; k <= 70; k++) begin
      if (k == 5) begin
        @(negedge clk);
        start_a = 1'b1;
        exp_a = 16'h0000;
      end
      @(posedge clk);
      #1;
      start_a = 1'b0;
      if (done_a) begin
        pulses++;
        if (first < 0) begin
          first = k + 1;
          checks++;
          if (mis_a !== 1'b0 || tbl_a !== 16'h6666) begin
            errors++;
            $display("FAIL restart_exp got mis=%b tbl=%h want 0 6666", mis_a, tbl_a);
          end
        end
      end
    end
    checks++;
    if (first !== 49 || pulses !== 1) begin
      errors++;
      $display("FAIL restart_done got cycle=%0d pulses=%0d want 49 1", first, pulses);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int pulses = 0;
    exp_a = 16'h6666;
    kick(0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({din_a, tbl_a, ones_a, busy_a, done_a, mis_a} !== '0) begin
      errors++;
      $display("FAIL midrst_zero got %h want 0",
               {din_a, tbl_a, ones_a, busy_a, done_a, mis_a});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (done_a || busy_a) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midrst_nodone got %0d active cycles want 0", pulses);
    end
    kick(0);
    wait_done(0, cyc);
    checks++;
    if (cyc !== 49 || tbl_a !== 16'h6666 || ones_a !== 5'd8 || mis_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rescan got cyc=%0d tbl=%h ones=%0d mis=%b want 49 6666 8 0",
               cyc, tbl_a, ones_a, mis_a);
    end
  endtask

  task automatic test_back_to_back;
    int at [3];
    int n = 0;
    tie1 = 1'b1;
    exp_b = 4'hF;
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 80 && n < 3; k++) begin
      @(posedge clk);
      #1;
      if (done_b) begin
        at[n] = k;
        n++;
        checks++;
        if (tbl_b !== 4'hF || ones_b !== 3'd4 || mis_b !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result_%0d got tbl=%h ones=%0d mis=%b want f 4 0",
                   n, tbl_b, ones_b, mis_b);
        end
        if (n == 3) start_b = 1'b0;
      end
    end
    start_b = 1'b0;
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", n);
    end else begin
      checks++;
      if (at[1] - at[0] !== 13 || at[2] - at[1] !== 13) begin
        errors++;
        $display("FAIL b2b_spacing got %0d %0d want 13 13",
                 at[1] - at[0], at[2] - at[1]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_b !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop got busy=%b want 0", busy_b);
    end
    tie1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_f4();
    test_f1_f2();
    test_f3();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
